// File: rtl/mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// command encodings, timer state encoding and default latencies.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6
  } mdu_op_e;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  // Counter must hold the longer of the two latencies.
  function automatic int mdu_cnt_width(input int mult_cycles, input int div_cycles);
    int longest;
    longest = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// Command/result bundle between the E stage and the multiply/divide unit.
interface e_mdu_if;

  logic        start;
  logic [3:0]  MDUop;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, MDUop, A, B,
    input  busy, HI, LO
  );

  modport slave (
    input  start, MDUop, A, B,
    output busy, HI, LO
  );

endinterface

// File: rtl/mdu_timer.sv
// Latency timer: a load starts a run of `length` busy cycles, and done
// pulses during the last one so the owner can commit on that edge.
module mdu_timer
  import mdu_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] length,
  output logic             busy,
  output logic             done
);

  mdu_state_e       state_q;
  mdu_state_e       state_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MDU_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Loads arriving while busy are dropped; the owner never issues them anyway.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done    = 1'b0;
    case (state_q)
      MDU_IDLE: begin
        if (load) begin
          state_d = MDU_BUSY;
          count_d = length - CNT_W'(1);
        end
      end
      MDU_BUSY: begin
        if (count_q == '0) begin
          done    = 1'b1;
          state_d = MDU_IDLE;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  assign busy = (state_q == MDU_BUSY);

endmodule

// File: rtl/e_mdu.sv
// Multiply/divide unit with architectural HI/LO. Results are computed at the
// start edge into shadow registers and become visible when the timer expires.
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input logic      clk,
  input logic      reset,
  e_mdu_if.slave   bus
);

  localparam int CNT_W = mdu_cnt_width(MULT_CYCLES, DIV_CYCLES);

  logic        accept;
  logic        timer_load;
  logic [CNT_W-1:0] timer_len;
  logic        timer_busy;
  logic        timer_done;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quot_u;
  logic        [31:0] rem_u;
  logic               div_ovf;

  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_commit;

  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] shadow_hi_q;
  logic [31:0] shadow_lo_q;
  logic        shadow_commit_q;

  assign accept = bus.start & ~timer_busy;

  assign prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
  assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};
  assign quot_s = $signed(bus.A) / $signed(bus.B);
  assign rem_s  = $signed(bus.A) % $signed(bus.B);
  assign quot_u = bus.A / bus.B;
  assign rem_u  = bus.A % bus.B;
  // The only signed quotient that does not fit in 32 bits; pinned explicitly.
  assign div_ovf = (bus.A == 32'h8000_0000) && (bus.B == 32'hFFFF_FFFF);

  always_comb begin
    res_hi     = '0;
    res_lo     = '0;
    res_commit = 1'b0;
    timer_load = 1'b0;
    timer_len  = '0;
    case (bus.MDUop)
      MDU_MULT: begin
        {res_hi, res_lo} = prod_s;
        res_commit = 1'b1;
        timer_load = accept;
        timer_len  = CNT_W'(MULT_CYCLES);
      end
      MDU_MULTU: begin
        {res_hi, res_lo} = prod_u;
        res_commit = 1'b1;
        timer_load = accept;
        timer_len  = CNT_W'(MULT_CYCLES);
      end
      MDU_DIV: begin
        timer_load = accept;
        timer_len  = CNT_W'(DIV_CYCLES);
        // Divide by zero keeps the full latency but leaves HI/LO untouched.
        if (bus.B != '0) begin
          res_commit = 1'b1;
          if (div_ovf) begin
            res_lo = 32'h8000_0000;
            res_hi = '0;
          end else begin
            res_lo = quot_s;
            res_hi = rem_s;
          end
        end
      end
      MDU_DIVU: begin
        timer_load = accept;
        timer_len  = CNT_W'(DIV_CYCLES);
        if (bus.B != '0) begin
          res_commit = 1'b1;
          res_lo     = quot_u;
          res_hi     = rem_u;
        end
      end
      default: ;
    endcase
  end

  mdu_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (timer_load),
    .length (timer_len),
    .busy   (timer_busy),
    .done   (timer_done)
  );

  // done and accept are mutually exclusive: done only occurs while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q            <= '0;
      lo_q            <= '0;
      shadow_hi_q     <= '0;
      shadow_lo_q     <= '0;
      shadow_commit_q <= 1'b0;
    end else if (timer_done) begin
      if (shadow_commit_q) begin
        hi_q <= shadow_hi_q;
        lo_q <= shadow_lo_q;
      end
    end else if (accept) begin
      case (bus.MDUop)
        MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
          shadow_hi_q     <= res_hi;
          shadow_lo_q     <= res_lo;
          shadow_commit_q <= res_commit;
        end
        MDU_MTHI: hi_q <= bus.A;
        MDU_MTLO: lo_q <= bus.A;
        default: ;
      endcase
    end
  end

  assign bus.busy = timer_busy;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule
